wb_init: RTL and testbench

Wishbone-style single-transfer initiator that drives the `mem_wb` memory responder. Accepts read/write commands from a local producer into a small command FIFO and issues them one at a time on the `strb`/`we`/`addr`/`wdata` bus. It waits for `ack`, then returns one response per command. Sits between test/system logic and `mem_wb`, replacing direct bus driving from the bench.

---
 rtl/wb_init.sv | 264 ++++++++++++++++++++++++++
 tb/tb_wb_init.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_init.sv
// ---------------------------------------------------------------------------
// wb_init -- Wishbone-style single-transfer bus initiator.
//
// Purpose:
//   Takes read/write commands from a local producer and queues them in a
//   small command FIFO. It issues them one at a time on the
//   strb/we/addr/wdata bus. It waits for ack, then returns exactly one
//   response pulse per command.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-low reset
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO can accept (not full)
//   cmd_we     in   1 = write, 0 = read
//   cmd_addr   in   target address   [ADDR_W]
//   cmd_wdata  in   write data       [DATA_W]
//   rsp_valid  out  one-cycle response pulse (no backpressure)
//   rsp_rdata  out  read data; 0 for writes and aborted transfers
//   rsp_err    out  transfer aborted by timeout (qualified by rsp_valid)
//   busy       out  FSM not idle or FIFO non-empty
//   level      out  FIFO occupancy   [$clog2(CMD_DEPTH)+1]
//   we/strb/addr/wdata  out  bus request
//   rdata      in   bus read data, valid with ack
//   ack        in   responder acknowledge
//
// Build option:
//   WB_INIT_TIMEOUT_EN  when defined, a transfer aborts with rsp_err=1 after
//                       TIMEOUT strobe cycles without ack. When undefined,
//                       XFER waits indefinitely and rsp_err is always 0.
// ---------------------------------------------------------------------------
module wb_init #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  // command side
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  // response side
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  // status
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   level,
  // bus side
  output logic                         we,
  output logic                         strb,
  output logic [ADDR_W-1:0]            addr,
  output logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W-1:0]            rdata,
  input  logic                         ack
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic              fifo_we_q    [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [CMD_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;

  logic              ready_w;
  logic              push;
  logic              pop;

  state_e            state_q, state_d;

  // cmd_ready reflects the pre-edge level, so a full FIFO refuses a command
  // even in the cycle where the FSM pops the head entry.
  always_comb begin
    ready_w = (level_q != LVL_W'(CMD_DEPTH));
    push    = cmd_valid && ready_w;
    pop     = (state_q == ST_IDLE) && (level_q != '0);
  end

  // Pointers are PTR_W bits wide and CMD_DEPTH is a power of two, so
  // they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= cmd_we;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // -------------------------------------------------------------------------
  // Transfer FSM
  // -------------------------------------------------------------------------
  logic              strb_q,      strb_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

`ifdef WB_INIT_TIMEOUT_EN
  logic [7:0]        tmo_q, tmo_d;
  logic              tmo_expire;

  // Expiry is detected on the last permitted strobe cycle, so strb is high
  // for exactly TIMEOUT cycles before the abort takes effect.
  always_comb begin
    tmo_expire = (tmo_q == 8'(TIMEOUT - 1));
  end
`else
  logic              unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  always_comb begin
    state_d     = state_q;
    strb_d      = strb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          we_d    = fifo_we_q[rd_ptr_q];
          addr_d  = fifo_addr_q[rd_ptr_q];
          wdata_d = fifo_wdata_q[rd_ptr_q];
          strb_d  = 1'b1;
          state_d = ST_XFER;
`ifdef WB_INIT_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end

      // ack is only looked at here, where strb is known to be high.
      ST_XFER: begin
        if (ack) begin
          rsp_rdata_d = we_q ? '0 : rdata;
          rsp_valid_d = 1'b1;
          strb_d      = 1'b0;
          we_d        = 1'b0;
          state_d     = ST_RESP;
`ifdef WB_INIT_TIMEOUT_EN
        end else if (tmo_expire) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          strb_d      = 1'b0;
          we_d        = 1'b0;
          state_d     = ST_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        strb_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      strb_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      strb_q      <= strb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef WB_INIT_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd_ready = ready_w;
  assign level     = level_q;
  assign busy      = (state_q != ST_IDLE) || (level_q != '0);
  assign strb      = strb_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_init.sv
module tb_wb_init;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic [2:0] level;
  logic       we;
  logic       strb;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;

  always #5 clk = ~clk;

  wb_init #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .CMD_DEPTH(4),
    .TIMEOUT  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .level    (level),
    .we       (we),
    .strb     (strb),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack)
  );

  // ---------------- responder model: memory initialised to addr ^ 0x3C ----
  logic [7:0]  mem [256];
  logic        mem_ready = 1'b0;
  int unsigned wait_cnt  = 0;
  logic        ack_en;
  int unsigned ack_dly;
  logic        force_ack;

  always_comb begin
    ack   = force_ack | (strb && ack_en && (wait_cnt >= ack_dly));
    rdata = mem[addr];
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
      mem_ready <= 1'b1;
    end else if (strb && ack && we) begin
      mem[addr] <= wdata;
    end
    if (!strb)     wait_cnt <= 0;
    else if (!ack) wait_cnt <= wait_cnt + 1;
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [7:0]  rdata;
    logic        err;
    int unsigned cyc;
  } rsp_t;

  rsp_t        rsp_log [256];
  int unsigned rsp_cnt  = 0;
  int unsigned cyc      = 0;
  int unsigned strb_cyc = 0;
  int unsigned stab_err = 0;
  logic        stab_en;
  logic        exp_we;
  logic [7:0]  exp_addr;
  logic [7:0]  exp_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_log[rsp_cnt[7:0]] = '{rdata: rsp_rdata, err: rsp_err, cyc: cyc};
      rsp_cnt++;
    end
    if (strb) begin
      strb_cyc++;
      if (stab_en && (we !== exp_we || addr !== exp_addr || wdata !== exp_wdata))
        stab_err++;
    end
  end

  // ---------------- checking helpers ----------------
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned rd_idx = 0;
  int unsigned push_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    int unsigned n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready still 0 after 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    push_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output rsp_t r);
    int unsigned n = 0;
    while (rsp_cnt <= rd_idx && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (rsp_cnt <= rd_idx) begin
      n_fail++;
      $display("FAIL rsp_wait: no response within 200 cycles, expected one");
      r = '{rdata: 8'h00, err: 1'b0, cyc: 0};
    end else begin
      r = rsp_log[rd_idx[7:0]];
      rd_idx++;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rsp_t        r, r0, r1, r2;
    int unsigned base, sbase, rc;

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    ack_en    = 1'b1;
    ack_dly   = 0;
    force_ack = 1'b0;
    stab_en   = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = 8'h00;
    exp_wdata = 8'h00;

    tbl[0] = '{1'b1, 8'h10, 8'h5A, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b0};
    tbl[2] = '{1'b0, 8'h20, 8'h00, 8'h1C, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'hA5, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h3C, 1'b0};
    tbl[6] = '{1'b1, 8'h00, 8'h11, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h11, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strb",      32'(strb),      32'd0);
    chk("rst_we",        32'(we),        32'd0);
    chk("rst_addr",      32'(addr),      32'd0);
    chk("rst_wdata",     32'(wdata),     32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single transfers
    for (int i = 0; i < 8; i++) begin
      send_cmd(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (i == 0) chk("busy_after_push", 32'(busy), 32'd1);
      get_rsp(r);
      chk($sformatf("vec%0d_rdata", i), 32'(r.rdata), 32'(tbl[i].exp_rdata));
      chk($sformatf("vec%0d_err", i),   32'(r.err),   32'(tbl[i].exp_err));
      if (i == 0) chk("first_latency", r.cyc - push_cyc, 32'd2);
    end

    // back-to-back reads with immediate ack: one response every 3 cycles
    send_cmd(1'b0, 8'h60, 8'h00);
    send_cmd(1'b0, 8'h61, 8'h00);
    send_cmd(1'b0, 8'h62, 8'h00);
    get_rsp(r0);
    get_rsp(r1);
    get_rsp(r2);
    chk("b2b_data0", 32'(r0.rdata), 32'h5C);
    chk("b2b_data1", 32'(r1.rdata), 32'h5D);
    chk("b2b_data2", 32'(r2.rdata), 32'h5E);
    chk("b2b_gap01", r1.cyc - r0.cyc, 32'd3);
    chk("b2b_gap12", r2.cyc - r1.cyc, 32'd3);

    // ack delayed by 3 cycles: 4 strobe cycles, stable bus, one pulse
    ack_dly   = 3;
    exp_we    = 1'b1;
    exp_addr  = 8'h30;
    exp_wdata = 8'h77;
    base      = strb_cyc;
    sbase     = stab_err;
    rc        = rsp_cnt;
    stab_en   = 1'b1;
    send_cmd(1'b1, 8'h30, 8'h77);
    get_rsp(r);
    stab_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("dly_strb_cycles", strb_cyc - base,  32'd4);
    chk("dly_bus_stable",  stab_err - sbase, 32'd0);
    chk("dly_one_pulse",   rsp_cnt - rc,     32'd1);
    chk("dly_rdata",       32'(r.rdata),     32'h00);
    ack_dly = 0;

    // bus stalled: fill the FIFO, extra command refused until a pop
    ack_en = 1'b0;
    rc     = rsp_cnt;
    for (int i = 0; i < 5; i++) send_cmd(1'b0, 8'h40 + 8'(i), 8'h00);
    chk("full_level",     32'(level),     32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    fork
      send_cmd(1'b0, 8'h45, 8'h00);
      begin
        repeat (4) @(negedge clk);
        chk("full_hold_level", 32'(level),    32'd4);
        chk("full_hold_ready", 32'(cmd_ready), 32'd0);
        chk("full_no_rsp",     rsp_cnt - rc,  32'd0);
        ack_en = 1'b1;
      end
    join
    for (int i = 0; i < 6; i++) begin
      get_rsp(r);
      chk($sformatf("order%0d_rdata", i), 32'(r.rdata), 32'((8'h40 + 8'(i)) ^ 8'h3C));
    end

`ifdef WB_INIT_TIMEOUT_EN
    // timeout: 16 strobe cycles, error response, next command proceeds
    ack_en = 1'b0;
    base   = strb_cyc;
    send_cmd(1'b0, 8'h50, 8'h00);
    send_cmd(1'b0, 8'h51, 8'h00);
    get_rsp(r);
    chk("tmo_strb_cycles", strb_cyc - base, 32'd16);
    chk("tmo_err",         32'(r.err),      32'd1);
    chk("tmo_rdata",       32'(r.rdata),    32'h00);
    ack_en = 1'b1;
    get_rsp(r);
    chk("tmo_next_err",   32'(r.err),   32'd0);
    chk("tmo_next_rdata", 32'(r.rdata), 32'h6D);
`endif

    // reset mid-transfer with two entries queued
    ack_en = 1'b0;
    send_cmd(1'b0, 8'h70, 8'h00);
    send_cmd(1'b0, 8'h71, 8'h00);
    send_cmd(1'b0, 8'h72, 8'h00);
    chk("pre_rst_level", 32'(level), 32'd2);
    chk("pre_rst_strb",  32'(strb),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_strb",      32'(strb),      32'd0);
    chk("mid_rst_level",     32'(level),     32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst    = 1'b1;
    rc     = rsp_cnt;
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_rsp", rsp_cnt - rc, 32'd0);
    chk("post_rst_strb",   32'(strb),    32'd0);

    // spurious ack while idle and empty
    rc = rsp_cnt;
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("spur_no_rsp", rsp_cnt - rc, 32'd0);
    chk("spur_busy",   32'(busy),    32'd0);
    chk("spur_strb",   32'(strb),    32'd0);
    chk("spur_level",  32'(level),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
